// File: rtl/call_push_sequencer_pkg.sv
// Shared types and defaults for the CALL push sequencer: FSM state encoding,
// push/flush lengths and the default datapath widths.
package call_seq_pkg;

  localparam int DEF_PC_W   = 32;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 20;

  // Return PC occupies two stack words; the front-end is squashed for two cycles.
  localparam int PUSH_WORDS   = 2;
  localparam int FLUSH_CYCLES = 2;

  typedef enum logic [2:0] {
    IDLE,
    PUSH_HI,
    PUSH_LO,
    JUMP,
    FLUSH1,
    FLUSH2,
    FAULT
  } state_t;

endpackage

// File: rtl/call_push_sequencer.sv
// Multi-cycle CALL sequencer: pushes the return PC as two stack words, commits SP,
// loads the target PC and flushes the front-end. Optional macro STACK_OVERFLOW_CHECK_EN.
module call_push_sequencer
  import call_seq_pkg::*;
#(
  parameter int PC_W   = DEF_PC_W,    // must equal 2*DATA_W
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              call_req,
  input  logic [PC_W-1:0]   ret_pc,
  input  logic [PC_W-1:0]   target_pc,
  input  logic [ADDR_W-1:0] sp_in,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              sp_we,
  output logic [ADDR_W-1:0] sp_next,
  output logic              pc_load,
  output logic [PC_W-1:0]   pc_load_val,
  output logic              stall,
  output logic              flush,
  output logic              busy
`ifdef STACK_OVERFLOW_CHECK_EN
  ,
  output logic              stack_fault
`endif
);

  state_t              state;
  // Only the low half of the return PC is needed after the first push cycle.
  logic [DATA_W-1:0]   ret_lo_l;
  logic [PC_W-1:0]     target_pc_l;
  logic [ADDR_W-1:0]   sp_l;

  // Every output is a register updated together with the state, so each output
  // reflects the state being entered; nothing here is combinational.
  // NOTE: async reset clears every register, outputs included, the moment rst_n
  // falls; all state updates use non-blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ret_lo_l    <= '0;
      target_pc_l <= '0;
      sp_l        <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      sp_we       <= 1'b0;
      sp_next     <= '0;
      pc_load     <= 1'b0;
      pc_load_val <= '0;
      stall       <= 1'b0;
      flush       <= 1'b0;
      busy        <= 1'b0;
`ifdef STACK_OVERFLOW_CHECK_EN
      stack_fault <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (call_req) begin
            ret_lo_l    <= ret_pc[DATA_W-1:0];
            target_pc_l <= target_pc;
            sp_l        <= sp_in;
            stall       <= 1'b1;
            busy        <= 1'b1;
`ifdef STACK_OVERFLOW_CHECK_EN
            if (sp_in < ADDR_W'(PUSH_WORDS)) begin
              state       <= FAULT;
              stack_fault <= 1'b1;
            end else begin
`endif
              // Latches load on this same edge, so the first word comes from the inputs.
              state     <= PUSH_HI;
              mem_we    <= 1'b1;
              mem_addr  <= sp_in;
              mem_wdata <= ret_pc[PC_W-1 -: DATA_W];
`ifdef STACK_OVERFLOW_CHECK_EN
            end
`endif
          end
        end

        PUSH_HI: begin
          if (mem_ready) begin
            state     <= PUSH_LO;
            mem_addr  <= sp_l - ADDR_W'(1);
            mem_wdata <= ret_lo_l;
          end
        end

        PUSH_LO: begin
          if (mem_ready) begin
            state       <= JUMP;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            sp_we       <= 1'b1;
            sp_next     <= sp_l - ADDR_W'(PUSH_WORDS);
            pc_load     <= 1'b1;
            pc_load_val <= target_pc_l;
          end
        end

        JUMP: begin
          state       <= FLUSH1;
          sp_we       <= 1'b0;
          sp_next     <= '0;
          pc_load     <= 1'b0;
          pc_load_val <= '0;
          flush       <= 1'b1;
        end

        FLUSH1: begin
          state <= FLUSH2;
        end

        FLUSH2: begin
          state <= IDLE;
          flush <= 1'b0;
          stall <= 1'b0;
          busy  <= 1'b0;
        end

`ifdef STACK_OVERFLOW_CHECK_EN
        FAULT: begin
          // Sticky until reset: the core stays stalled with the fault flagged.
          state <= FAULT;
        end
`endif

        default: begin
          state       <= IDLE;
          mem_we      <= 1'b0;
          mem_addr    <= '0;
          mem_wdata   <= '0;
          sp_we       <= 1'b0;
          sp_next     <= '0;
          pc_load     <= 1'b0;
          pc_load_val <= '0;
          stall       <= 1'b0;
          flush       <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_call_push_sequencer.sv
// Directed bench for call_push_sequencer: a queue-of-actions model checked every
// cycle, plus hand-computed literal checks for each scenario.
module tb_call_push_sequencer;

  logic        clk;
  logic        rst_n;
  logic        call_req;
  logic [31:0] ret_pc;
  logic [31:0] target_pc;
  logic [19:0] sp_in;
  logic        mem_ready;
  logic        mem_we;
  logic [19:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        sp_we;
  logic [19:0] sp_next;
  logic        pc_load;
  logic [31:0] pc_load_val;
  logic        stall;
  logic        flush;
  logic        busy;
  logic        fault_sig;

  int vectors = 0;
  int errors  = 0;
  int pc_load_cnt = 0;
  int sp_we_cnt   = 0;

  call_push_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .call_req    (call_req),
    .ret_pc      (ret_pc),
    .target_pc   (target_pc),
    .sp_in       (sp_in),
    .mem_ready   (mem_ready),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .sp_we       (sp_we),
    .sp_next     (sp_next),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .stall       (stall),
    .flush       (flush),
    .busy        (busy)
`ifdef STACK_OVERFLOW_CHECK_EN
    ,
    .stack_fault (fault_sig)
`endif
  );

`ifndef STACK_OVERFLOW_CHECK_EN
  assign fault_sig = 1'b0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted CALL becomes a list of outstanding actions; the head of the
  // list defines what the outputs must show this cycle.
  typedef enum {A_WRITE, A_JUMP, A_FLUSH, A_FAULT} act_e;
  typedef struct {
    act_e        kind;
    logic [19:0] addr;
    logic [15:0] data;
    logic [31:0] pc;
  } act_t;

  act_t q[$];

  function automatic act_t mk(act_e k, logic [19:0] a, logic [15:0] d, logic [31:0] p);
    act_t r;
    r.kind = k; r.addr = a; r.data = d; r.pc = p;
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst_n) begin
      if (q.size() == 0) begin
        if (call_req) begin
`ifdef STACK_OVERFLOW_CHECK_EN
          if (sp_in < 20'd2) q.push_back(mk(A_FAULT, 20'd0, 16'd0, 32'd0));
          else begin
`endif
            q.push_back(mk(A_WRITE, sp_in, ret_pc[31:16], 32'd0));
            q.push_back(mk(A_WRITE, sp_in - 20'd1, ret_pc[15:0], 32'd0));
            q.push_back(mk(A_JUMP, sp_in - 20'd2, 16'd0, target_pc));
            q.push_back(mk(A_FLUSH, 20'd0, 16'd0, 32'd0));
            q.push_back(mk(A_FLUSH, 20'd0, 16'd0, 32'd0));
`ifdef STACK_OVERFLOW_CHECK_EN
          end
`endif
        end
      end else if (q[0].kind == A_FAULT) begin
        // stays until reset
      end else if (!(q[0].kind == A_WRITE && !mem_ready)) begin
        void'(q.pop_front());
      end
    end
  end

  always @(negedge rst_n) q.delete();

  // Compare on the falling edge, well away from the active edge.
  always @(negedge clk) begin
    logic [94:0] exp_v, act_v;
    exp_v = '0;
    if (q.size() != 0) begin
      case (q[0].kind)
        A_WRITE: exp_v = {1'b1, q[0].addr, q[0].data, 1'b0, 20'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        A_JUMP:  exp_v = {1'b0, 20'd0, 16'd0, 1'b1, q[0].addr, 1'b1, q[0].pc, 1'b1, 1'b0, 1'b1, 1'b0};
        A_FLUSH: exp_v = {1'b0, 20'd0, 16'd0, 1'b0, 20'd0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b0};
        A_FAULT: exp_v = {1'b0, 20'd0, 16'd0, 1'b0, 20'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b1};
        default: exp_v = '0;
      endcase
    end
    act_v = {mem_we, mem_addr, mem_wdata, sp_we, sp_next, pc_load, pc_load_val,
             stall, flush, busy, fault_sig};
    check("cycle_model", 128'(act_v), 128'(exp_v));
    if (pc_load === 1'b1) pc_load_cnt++;
    if (sp_we === 1'b1) sp_we_cnt++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int base_pc, base_sp;

  initial begin
    rst_n = 1'b0; call_req = 1'b0; ret_pc = '0; target_pc = '0;
    sp_in = '0; mem_ready = 1'b1;
    #12;
    check("reset_outputs", {mem_we, sp_we, pc_load, stall, flush, busy, fault_sig}, 7'd0);
    #2 rst_n = 1'b1;
    step(2);

    // Basic call with memory always ready.
    ret_pc = 32'h0001_2345; target_pc = 32'h0000_0400; sp_in = 20'hFFFFF; call_req = 1'b1;
    step(1);
    call_req = 1'b0;
    check("basic_hi", {mem_we, mem_addr, mem_wdata}, {1'b1, 20'hFFFFF, 16'h0001});
    step(1);
    check("basic_lo", {mem_we, mem_addr, mem_wdata}, {1'b1, 20'hFFFFE, 16'h2345});
    step(1);
    check("basic_jump", {sp_we, sp_next, pc_load, pc_load_val}, {1'b1, 20'hFFFFD, 1'b1, 32'h400});
    step(1);
    check("basic_flush1", {flush, busy, mem_we}, 3'b110);
    step(1);
    check("basic_flush2", {flush, busy}, 2'b11);
    step(1);
    check("basic_idle", {busy, stall, flush}, 3'b000);
    step(2);

    // Backpressure: three not-ready cycles in PUSH_HI.
    mem_ready = 1'b0; call_req = 1'b1;
    step(1);
    call_req = 1'b0;
    step(3);
    check("bp_hold", {mem_we, mem_addr, mem_wdata}, {1'b1, 20'hFFFFF, 16'h0001});
    mem_ready = 1'b1;
    step(1);
    check("bp_lo", {mem_we, mem_addr, mem_wdata}, {1'b1, 20'hFFFFE, 16'h2345});
    step(1);
    check("bp_jump", {sp_next, pc_load_val}, {20'hFFFFD, 32'h400});
    step(3);
    check("bp_idle", busy, 1'b0);
    step(1);

`ifndef STACK_OVERFLOW_CHECK_EN
    // Address wrap below zero.
    ret_pc = 32'hABCD_1234; target_pc = 32'h8000_0000; sp_in = 20'h00001; call_req = 1'b1;
    step(1);
    call_req = 1'b0;
    check("wrap_hi", {mem_addr, mem_wdata}, {20'h00001, 16'hABCD});
    step(1);
    check("wrap_lo", {mem_addr, mem_wdata}, {20'h00000, 16'h1234});
    step(1);
    check("wrap_sp", {sp_next, pc_load_val}, {20'hFFFFF, 32'h8000_0000});
    step(4);
`endif

    // Second CALL while busy must be ignored; later input changes must not leak in.
    base_pc = pc_load_cnt;
    ret_pc = 32'h0000_1000; target_pc = 32'h0000_0400; sp_in = 20'h00100; call_req = 1'b1;
    step(1);
    call_req = 1'b0;
    step(1);
    call_req = 1'b1; target_pc = 32'h0000_0999; sp_in = 20'h00500;
    step(1);
    call_req = 1'b0;
    check("ignore_jump", {pc_load, pc_load_val, sp_next}, {1'b1, 32'h400, 20'h000FE});
    step(4);
    check("ignore_count", pc_load_cnt - base_pc, 1);

    // Asynchronous reset during PUSH_LO.
    base_pc = pc_load_cnt; base_sp = sp_we_cnt;
    target_pc = 32'h0000_2000; sp_in = 20'h00200; call_req = 1'b1;
    step(1);
    call_req = 1'b0;
    step(1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_zero", {mem_we, mem_addr, mem_wdata, stall, busy, flush},
          {1'b0, 20'd0, 16'd0, 3'b000});
    #3 rst_n = 1'b1;
    step(3);
    check("rst_no_commit", {pc_load_cnt - base_pc, sp_we_cnt - base_sp}, 64'd0);
    call_req = 1'b1;
    step(1);
    call_req = 1'b0;
    step(2);
    check("rst_recover", {pc_load, pc_load_val, sp_next}, {1'b1, 32'h2000, 20'h001FE});
    step(4);

    // call_req held high: back-to-back sequences with one IDLE cycle between.
    call_req = 1'b1;
    step(6);
    check("held_idle_gap", busy, 1'b0);
    step(1);
    check("held_restart", {mem_we, busy}, 2'b11);
    call_req = 1'b0;
    step(7);

`ifdef STACK_OVERFLOW_CHECK_EN
    // Overflow guard: sticky fault, no writes.
    sp_in = 20'h00001; call_req = 1'b1;
    step(1);
    call_req = 1'b0;
    check("fault_set", {fault_sig, stall, mem_we, pc_load}, 4'b1100);
    step(5);
    check("fault_sticky", {fault_sig, stall, busy}, 3'b111);
    #2 rst_n = 1'b0;
    #1;
    check("fault_clear", {fault_sig, stall}, 2'b00);
    #3 rst_n = 1'b1;
    step(2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
